eight_bit_serializer: RTL and testbench
=======================================

EIGHT_BIT_SERIALIZER -- requirements
Module: eight_bit_serializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = bit 0 shifted out first, 0 = bit 7 first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in  input  8  parallel byte to transmit.
REQ-005 load_valid  input  1  producer asserts when in holds a byte to send.
REQ-006 load_ready  output  1  high when the block can accept a byte.
REQ-007 ser_out  output  1  serial data bit.
REQ-008 ser_valid  output  1  high on every cycle ser_out carries a frame bit.
REQ-009 busy  output  1  high while a frame is in progress (SHIFT, PARITY or DONE states).
REQ-010 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, PARITY, DONE; all outputs registered except load_ready.
REQ-012 load_ready SHALL equal (state == IDLE).
REQ-013 Accept occurs on a rising edge with load_valid && load_ready: in captured into 8-bit shift register, bit counter cleared, state -> SHIFT.
REQ-014 First data bit SHALL appear on ser_out with ser_valid=1 in the cycle after accept (latency 1).
REQ-015 In SHIFT, one bit per cycle in LSB_FIRST order; counter increments 0..7, no gaps.
REQ-016 On counter == 7: next state PARITY if PARITY_EN defined, else DONE.
REQ-017 PARITY: ser_out = even parity (XOR) of captured byte, ser_valid=1, one cycle, then DONE.
REQ-018 DONE: ser_valid=0, done=1 for exactly one cycle, then IDLE.
REQ-019 load_valid outside IDLE SHALL be ignored; in changes after accept SHALL NOT affect the frame.
REQ-020 Minimum accept-to-accept spacing: 10 cycles (11 with PARITY_EN); back-to-back bytes have one IDLE cycle between them.
REQ-021 In IDLE and DONE, ser_out SHALL be 0.
REQ-022 Counter SHALL never wrap inside a frame; counter value outside SHIFT is don't-care but SHALL be cleared on accept.

Reset
REQ-023 rst low SHALL immediately force state IDLE, shift register 0, counter 0, ser_out 0, ser_valid 0, busy 0, done 0; load_ready 1.
REQ-024 Reset mid-frame SHALL abort the frame with no done pulse; first accept after rst deasserts starts a fresh frame.

Configuration
REQ-025 Macro SERIALIZER_PARITY_EN: defined -> PARITY state present, 9-bit frames; undefined -> PARITY state unreachable/removed, 8-bit frames, ports unchanged.

Structure
REQ-026 Package eight_bit_serializer_pkg SHALL hold the state enum typedef, BIT_CNT_W = 3, DATA_W = 8, FRAME_LEN (8 or 9 per macro).
REQ-027 One sub-module piso_shift_reg (8-bit parallel load, shift, direction by LSB_FIRST, async active-low reset); FSM and counter in the top.

Verification
REQ-028 Reset, then load 0xA5, LSB_FIRST=1, no parity -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles, then done pulse.
REQ-029 LSB_FIRST=0, load 0x81 -> ser_out 1,0,0,0,0,0,0,1; busy high 9 cycles total.
REQ-030 PARITY_EN defined, load 0x07 -> bits 1,1,1,0,0,0,0,0 then parity 1; load 0xA5 -> parity bit 0.
REQ-031 Hold load_valid=1 with changing in during frame -> only first byte sent, load_ready 0 until IDLE, second byte accepted one cycle after done.
REQ-032 Assert rst low on 4th bit of 0xFF frame -> all outputs 0 same cycle, no done; next load 0x00 sends eight 0 bits normally.

Source files
------------

// File: rtl/eight_bit_serializer_pkg.sv
// Shared types and constants for the eight-bit serializer.
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit (9-bit frames).
package eight_bit_serializer_pkg;

    localparam int DATA_W    = 8;
    localparam int BIT_CNT_W = 3;

`ifdef SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    // Counter value while the last data bit is on the line.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit that leaves the block first for a given byte and shift direction.
    function automatic logic head_bit(input logic [DATA_W-1:0] d, input bit lsb_first);
        return lsb_first ? d[0] : d[DATA_W-1];
    endfunction

endpackage

// File: rtl/eight_bit_serializer_piso_shift_reg.sv
// Parallel-in serial-out shift register for the serializer.
// Loads a byte, then shifts one position per cycle toward the output end.
// next_bit is the bit that becomes the head after the next shift, so the
// top can register it onto the serial line in the same edge as the shift.
module piso_shift_reg
    import eight_bit_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              next_bit
);

    logic [DATA_W-1:0] q;

    // Load has priority over shift; shifted-in bits are zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            if (LSB_FIRST) begin
                q <= {1'b0, q[DATA_W-1:1]};
            end else begin
                q <= {q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign next_bit = LSB_FIRST ? q[1] : q[DATA_W-2];

endmodule

// File: rtl/eight_bit_serializer.sv
// Eight-bit serializer: accepts a byte over a valid/ready load port and
// sends it one bit per cycle, optionally followed by an even-parity bit.
// Build option: define SERIALIZER_PARITY_EN to add the PARITY state.
//
// Load handshake: a byte transfers on a rising edge where load_valid and
// load_ready are both high. load_ready is high only in IDLE; load_valid in
// any other state is ignored, and in is not sampled again until the next
// transfer, so it may change freely once the byte has been taken.
module eight_bit_serializer
    import eight_bit_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg
);

    state_t               state;
    state_t               state_nxt;
    logic [BIT_CNT_W-1:0] cnt;
    logic                 accept;
    logic                 next_bit;
    logic                 ser_out_nxt;
    logic                 ser_valid_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;

    assign load_ready = (state == IDLE);
    assign accept     = load_valid && load_ready;
    assign state_dbg  = state;

    piso_shift_reg #(
        .LSB_FIRST(LSB_FIRST)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst),
        .load     (accept),
        .shift    (state == SHIFT),
        .din      (in),
        .next_bit (next_bit)
    );

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    // Parity is taken from the whole byte at accept, before shifting consumes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^in;
        end
    end
`endif

    // Next state plus the values the registered outputs take on entering it.
    always_comb begin
        state_nxt     = state;
        ser_out_nxt   = 1'b0;
        ser_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt     = SHIFT;
                    ser_out_nxt   = head_bit(in, LSB_FIRST);
                    ser_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt     = PARITY;
                    ser_out_nxt   = parity_q;
                    ser_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
`else
                    state_nxt     = DONE;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b1;
`endif
                end else begin
                    ser_out_nxt   = next_bit;
                    ser_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                end
            end
            PARITY: begin
                state_nxt = DONE;
                busy_nxt  = 1'b1;
                done_nxt  = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ser_out   <= ser_out_nxt;
            ser_valid <= ser_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Bit counter: cleared on accept, stops at the last bit so it never wraps in a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if ((state == SHIFT) && (cnt != LAST_BIT)) begin
            cnt <= cnt + BIT_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_eight_bit_serializer.sv
// Directed testbench for eight_bit_serializer.
// dut_a runs LSB-first, dut_b runs MSB-first; both share clock and reset.
// Define SERIALIZER_PARITY_EN for both RTL and bench to cover the parity build.
module tb_eight_bit_serializer;
    import eight_bit_serializer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic [7:0] in_a, in_b;
    logic       lv_a, lv_b;
    logic       ready_a, ser_out_a, ser_valid_a, busy_a, done_a;
    logic       ready_b, ser_out_b, ser_valid_b, busy_b, done_b;
    state_t     state_a, state_b;

    eight_bit_serializer #(.LSB_FIRST(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in         (in_a),
        .load_valid (lv_a),
        .load_ready (ready_a),
        .ser_out    (ser_out_a),
        .ser_valid  (ser_valid_a),
        .busy       (busy_a),
        .done       (done_a),
        .state_dbg  (state_a)
    );

    eight_bit_serializer #(.LSB_FIRST(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in         (in_b),
        .load_valid (lv_b),
        .load_ready (ready_b),
        .ser_out    (ser_out_b),
        .ser_valid  (ser_valid_b),
        .busy       (busy_b),
        .done       (done_b),
        .state_dbg  (state_b)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // seq holds the data bits in transmission order, first bit at seq[7].
    task automatic push_frame(input logic [7:0] seq, input logic par);
        for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back(par);
`else
        if (par) begin end
`endif
    endtask

    // ---------------- drivers ----------------
    // Offer a byte to dut_a in IDLE; returns at the negedge after the accepting edge.
    task automatic send_a(input string tag, input logic [7:0] b);
        @(negedge clk);
        check({tag, "_ready"}, 32'(ready_a), 32'd1);
        in_a = b;
        lv_a = 1'b1;
        @(negedge clk);
        lv_a = 1'b0;
        in_a = ~b;
    endtask

    // Called at the first negedge after accept; consumes exp_q and checks the
    // done pulse and return to IDLE. With jitter, in_a is scrambled every cycle.
    task automatic frame_check(input string tag, input bit jitter);
        logic [0:0] e;
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_bit%0d", tag, i), 32'(ser_out_a), 32'(e));
            check($sformatf("%s_valid%0d", tag, i), 32'(ser_valid_a), 32'd1);
            check($sformatf("%s_busy%0d", tag, i), 32'(busy_a), 32'd1);
            check($sformatf("%s_nready%0d", tag, i), 32'(ready_a), 32'd0);
            if (jitter) in_a = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_done_valid"}, 32'(ser_valid_a), 32'd0);
        check({tag, "_done_out"}, 32'(ser_out_a), 32'd0);
        check({tag, "_done_busy"}, 32'(busy_a), 32'd1);
        if (jitter) in_a = 8'($urandom_range(0, 255));
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done_a), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_idle_ready"}, 32'(ready_a), 32'd1);
        check({tag, "_idle_state"}, 32'(state_a), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] got_b;
    int          nv, nb, nd;

    initial begin
        rst  = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        lv_a = 1'b0;
        lv_b = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_ser_out", 32'(ser_out_a), 32'd0);
        check("rst_valid", 32'(ser_valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_state", 32'(state_a), 32'(IDLE));
        rst = 1'b1;

        // 0xA5 LSB-first: 1,0,1,0,0,1,0,1 ; parity 0
        push_frame(8'b1010_0101, 1'b0);
        send_a("a5", 8'hA5);
        frame_check("a5", 1'b0);

        // 0x07 LSB-first: 1,1,1,0,0,0,0,0 ; parity 1
        push_frame(8'b1110_0000, 1'b1);
        send_a("x07", 8'h07);
        frame_check("x07", 1'b0);

        // 0x81 MSB-first on dut_b: 1,0,0,0,0,0,0,1 ; busy 9 cycles (10 with parity)
        @(negedge clk);
        check("b_ready", 32'(ready_b), 32'd1);
        in_b = 8'h81;
        lv_b = 1'b1;
        @(negedge clk);
        lv_b = 1'b0;
        in_b = 8'h00;
        got_b = '0;
        nv = 0;
        nb = 0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (ser_valid_b) begin
                got_b = {got_b[14:0], ser_out_b};
                nv++;
            end
            if (busy_b) nb++;
            if (done_b) nd++;
            @(negedge clk);
        end
`ifdef SERIALIZER_PARITY_EN
        check("b_nbits", 32'(nv), 32'd9);
        check("b_bits", 32'(got_b[8:1]), 32'h81);
        check("b_parity", 32'(got_b[0]), 32'd0);
        check("b_busy_len", 32'(nb), 32'd10);
`else
        check("b_nbits", 32'(nv), 32'd8);
        check("b_bits", 32'(got_b[7:0]), 32'h81);
        check("b_busy_len", 32'(nb), 32'd9);
`endif
        check("b_done_cnt", 32'(nd), 32'd1);
        check("b_state", 32'(state_b), 32'(IDLE));

        // load_valid held with changing in: only 0x3C sent, then 0xC3 accepted in the IDLE cycle after done
        push_frame(8'b0011_1100, 1'b0);
        @(negedge clk);
        in_a = 8'h3C;
        lv_a = 1'b1;
        @(negedge clk);
        frame_check("hold1", 1'b1);
        in_a = 8'hC3;
        @(negedge clk);
        lv_a = 1'b0;
        in_a = 8'h00;
        push_frame(8'b1100_0011, 1'b0);
        frame_check("hold2", 1'b0);

        // Reset on the 4th bit of 0xFF aborts the frame with no done pulse
        send_a("ff", 8'hFF);
        repeat (3) @(negedge clk);
        check("ff_bit3", 32'(ser_out_a), 32'd1);
        check("ff_bit3_valid", 32'(ser_valid_a), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_ser_out", 32'(ser_out_a), 32'd0);
        check("abort_valid", 32'(ser_valid_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_ready", 32'(ready_a), 32'd1);
        check("abort_state", 32'(state_a), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a || ser_valid_a) nd++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(nd), 32'd0);

        // Fresh frame after reset: 0x00 sends eight zeros
        push_frame(8'b0000_0000, 1'b0);
        send_a("x00", 8'h00);
        frame_check("x00", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
